// File: rtl/order_match_engine.sv
// Two-sided order book with cross detection, trade counting and halt control.
// Optional feature: define SPREAD_HALT_EN to halt from QUOTE when the spread exceeds MAX_SPREAD.
module order_match_engine #(
    parameter logic [7:0] MAX_SPREAD  = 8'd50,
    parameter logic [7:0] TRADE_LIMIT = 8'd20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       buy_valid,
    input  logic [7:0] buy_in,
    input  logic       sell_valid,
    input  logic [7:0] sell_in,
    input  logic       resume,
    output logic       order_ready,
    output logic [7:0] buy_price,
    output logic [7:0] sell_price,
    output logic [7:0] spread_now,
    output logic [7:0] trade_count,
    output logic [1:0] state,
    output logic       halt_signal,
    output logic       match_signal
);

`ifdef SPREAD_HALT_EN
    localparam bit SPREAD_HALT = 1'b1;
`else
    localparam bit SPREAD_HALT = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        QUOTE = 2'b01,
        MATCH = 2'b10,
        HALT  = 2'b11
    } state_t;

    state_t     state_r;
    logic       has_bid_r;
    logic       has_ask_r;
    logic       limit_halt_r;

    logic [7:0] bid_s;
    logic [7:0] ask_s;
    logic       has_bid_s;
    logic       has_ask_s;
    logic [7:0] spread_s;
    logic       cross_s;
    logic       spread_halt_s;

    // Prices feed two-digit displays, so anything above 99 is pinned to 99.
    function automatic logic [7:0] clamp_price(input logic [7:0] p);
        return (p > 8'd99) ? 8'd99 : p;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'd255) ? 8'd255 : v + 8'd1;
    endfunction

    assign state = state_r;

    // Book contents after this cycle's captures, and decisions on the registered book.
    always_comb begin
        bid_s     = buy_price;
        ask_s     = sell_price;
        has_bid_s = has_bid_r;
        has_ask_s = has_ask_r;
        if (buy_valid && order_ready) begin
            bid_s     = clamp_price(buy_in);
            has_bid_s = 1'b1;
        end else begin
            bid_s     = buy_price;
        end
        if (sell_valid && order_ready) begin
            ask_s     = clamp_price(sell_in);
            has_ask_s = 1'b1;
        end else begin
            ask_s     = sell_price;
        end
        if (has_bid_s && has_ask_s && (ask_s > bid_s)) begin
            spread_s = ask_s - bid_s;
        end else begin
            spread_s = 8'd0;
        end
        cross_s       = has_bid_r && has_ask_r && (buy_price >= sell_price);
        spread_halt_s = SPREAD_HALT && (spread_now > MAX_SPREAD);
    end

    // Engine FSM together with the book and every registered output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            has_bid_r    <= 1'b0;
            has_ask_r    <= 1'b0;
            limit_halt_r <= 1'b0;
            order_ready  <= 1'b0;
            buy_price    <= 8'd0;
            sell_price   <= 8'd0;
            spread_now   <= 8'd0;
            trade_count  <= 8'd0;
            halt_signal  <= 1'b0;
            match_signal <= 1'b0;
        end else begin
            case (state_r)
                IDLE, QUOTE: begin
                    buy_price  <= bid_s;
                    sell_price <= ask_s;
                    has_bid_r  <= has_bid_s;
                    has_ask_r  <= has_ask_s;
                    spread_now <= spread_s;
                    // A cross wins over a spread halt.
                    if (cross_s) begin
                        state_r      <= MATCH;
                        match_signal <= 1'b1;
                        order_ready  <= 1'b0;
                        trade_count  <= sat_inc(trade_count);
                    end else if ((state_r == QUOTE) && spread_halt_s) begin
                        state_r      <= HALT;
                        halt_signal  <= 1'b1;
                        limit_halt_r <= 1'b0;
                        order_ready  <= 1'b0;
                    end else if (has_bid_r && has_ask_r) begin
                        state_r     <= QUOTE;
                        order_ready <= 1'b1;
                    end else begin
                        state_r     <= IDLE;
                        order_ready <= 1'b1;
                    end
                end
                MATCH: begin
                    match_signal <= 1'b0;
                    has_bid_r    <= 1'b0;
                    has_ask_r    <= 1'b0;
                    spread_now   <= 8'd0;
                    if (trade_count == TRADE_LIMIT) begin
                        state_r      <= HALT;
                        halt_signal  <= 1'b1;
                        limit_halt_r <= 1'b1;
                        order_ready  <= 1'b0;
                    end else begin
                        state_r      <= IDLE;
                        order_ready  <= 1'b1;
                    end
                end
                HALT: begin
                    if (resume) begin
                        state_r      <= IDLE;
                        halt_signal  <= 1'b0;
                        has_bid_r    <= 1'b0;
                        has_ask_r    <= 1'b0;
                        spread_now   <= 8'd0;
                        order_ready  <= 1'b1;
                        limit_halt_r <= 1'b0;
                        // Only a trade-limit halt restarts the count.
                        if (limit_halt_r) begin
                            trade_count <= 8'd0;
                        end else begin
                            trade_count <= trade_count;
                        end
                    end else begin
                        state_r <= HALT;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    order_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
